pixel_mul: RTL and testbench

Unsigned 16×16 multiplier used by the image-processing datapath to blend two 8-bit luminance samples; each pixel pair is zero-extended to 16 bits and multiplied. The primary product output is purely combinational and truncated to 16 bits, so the consumer can use it in the same cycle (typically `p >> 8`). A registered copy of the product and an overflow flag are also provided for pipelined consumers.

---
 rtl/pixel_mul_if.sv | 31 +++
 rtl/pixel_mul.sv | 38 +++
 tb/tb_pixel_mul.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_mul_if.sv
// Operand/product bundle for pixel_mul: operands in, combinational and registered products out.
interface pixel_mul_if #(
    parameter int unsigned N = 16
) ();
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] p;
    logic         ovf;
    logic [N-1:0] p_q;
    logic         ovf_q;

    // Operand source side.
    modport master (
        output a,
        output b,
        input  p,
        input  ovf,
        input  p_q,
        input  ovf_q
    );

    // Multiplier side.
    modport slave (
        input  a,
        input  b,
        output p,
        output ovf,
        output p_q,
        output ovf_q
    );
endinterface

// File: rtl/pixel_mul.sv
// Unsigned NxN shift-and-add multiplier with a truncated combinational product,
// an overflow flag, and a one-cycle registered copy of both.
module pixel_mul #(
    parameter int unsigned N = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    pixel_mul_if.slave  bus
);
    localparam int unsigned PW = 2 * N;

    logic [PW-1:0] prod;

    // Sum the N partial products (a << i) gated by b[i]; full 2N-bit result.
    always_comb begin
        prod = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (bus.b[i]) begin
                prod = prod + (PW'(bus.a) << i);
            end
        end
    end

    // Truncated product and overflow from the discarded upper half.
    assign bus.p   = prod[N-1:0];
    assign bus.ovf = |prod[PW-1:N];

    // Registered copy for pipelined consumers; async reset clears any captured value.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bus.p_q   <= '0;
            bus.ovf_q <= 1'b0;
        end else begin
            bus.p_q   <= bus.p;
            bus.ovf_q <= bus.ovf;
        end
    end
endmodule

// File: tb/tb_pixel_mul.sv
// Self-checking bench for pixel_mul: directed corners, random 8/16-bit operands,
// registered-path latency and asynchronous reset behaviour.
module tb_pixel_mul;
    logic HCLK;
    logic HRESETn;
    int   n_pass;
    int   n_total;

    pixel_mul_if #(.N(16)) bus ();

    pixel_mul #(.N(16)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Reference: plain 32-bit arithmetic on the operands.
    function automatic logic [15:0] ref_p(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] full;
        full = 32'(x) * 32'(y);
        return full[15:0];
    endfunction

    function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] full;
        full = 32'(x) * 32'(y);
        return full > 32'h0000_FFFF;
    endfunction

    task automatic test_reset();
        HRESETn = 1'b0;
        bus.a = 16'h0012;
        bus.b = 16'h0034;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        n_total++;
        if (bus.p_q !== 16'h0000) $display("FAIL reset_p_q: got %h want 0000", bus.p_q);
        else n_pass++;
        n_total++;
        if (bus.ovf_q !== 1'b0) $display("FAIL reset_ovf_q: got %b want 0", bus.ovf_q);
        else n_pass++;
        n_total++;
        if (bus.p !== 16'h03A8) $display("FAIL reset_p_tracks: got %h want 03a8", bus.p);
        else n_pass++;
        HRESETn = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] va   [5] = '{16'h00FF, 16'h0000, 16'h0001, 16'h0100, 16'hFFFF};
        logic [15:0] vb   [5] = '{16'h00FF, 16'hFFFF, 16'h1234, 16'h0100, 16'hFFFF};
        logic [15:0] vp   [5] = '{16'hFE01, 16'h0000, 16'h1234, 16'h0000, 16'h0001};
        logic        vovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            bus.a = va[i];
            bus.b = vb[i];
            #1;
            n_total++;
            if (bus.p !== vp[i]) $display("FAIL dir_p[%0d]: got %h want %h", i, bus.p, vp[i]);
            else n_pass++;
            n_total++;
            if (bus.ovf !== vovf[i]) $display("FAIL dir_ovf[%0d]: got %b want %b", i, bus.ovf, vovf[i]);
            else n_pass++;
            if (i == 0) begin
                n_total++;
                if (bus.p[15:8] !== 8'hFE) $display("FAIL dir_blend: got %h want fe", bus.p[15:8]);
                else n_pass++;
            end
            @(negedge HCLK);
            n_total++;
            if (bus.p_q !== vp[i]) $display("FAIL dir_p_q[%0d]: got %h want %h", i, bus.p_q, vp[i]);
            else n_pass++;
            n_total++;
            if (bus.ovf_q !== vovf[i]) $display("FAIL dir_ovf_q[%0d]: got %b want %b", i, bus.ovf_q, vovf[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random8();
        int errs;
        errs = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge HCLK);
            bus.a = {8'h00, 8'($urandom)};
            bus.b = {8'h00, 8'($urandom)};
            #1;
            n_total++;
            if (bus.p !== ref_p(bus.a, bus.b) || bus.ovf !== 1'b0) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL rand8 a=%h b=%h: got p=%h ovf=%b want p=%h ovf=0",
                             bus.a, bus.b, bus.p, bus.ovf, ref_p(bus.a, bus.b));
            end else n_pass++;
        end
    endtask

    task automatic test_random16();
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge HCLK);
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            #1;
            n_total++;
            if (bus.p !== ref_p(bus.a, bus.b) || bus.ovf !== ref_ovf(bus.a, bus.b)) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL rand16 a=%h b=%h: got p=%h ovf=%b want p=%h ovf=%b",
                             bus.a, bus.b, bus.p, bus.ovf,
                             ref_p(bus.a, bus.b), ref_ovf(bus.a, bus.b));
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_p;
        logic        exp_ovf;
        exp_p   = '0;
        exp_ovf = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge HCLK);
            if (k > 0) begin
                n_total++;
                if (bus.p_q !== exp_p) $display("FAIL b2b_p_q[%0d]: got %h want %h", k, bus.p_q, exp_p);
                else n_pass++;
                n_total++;
                if (bus.ovf_q !== exp_ovf) $display("FAIL b2b_ovf_q[%0d]: got %b want %b", k, bus.ovf_q, exp_ovf);
                else n_pass++;
            end
            if (k < 5) begin
                bus.a   = 16'($urandom);
                bus.b   = 16'($urandom);
                exp_p   = ref_p(bus.a, bus.b);
                exp_ovf = ref_ovf(bus.a, bus.b);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge HCLK);
        bus.a = 16'h0080;
        bus.b = 16'h0002;
        @(negedge HCLK);
        n_total++;
        if (bus.p_q !== 16'h0100) $display("FAIL mid_pre_p_q: got %h want 0100", bus.p_q);
        else n_pass++;
        #2;
        HRESETn = 1'b0;
        #1;
        n_total++;
        if (bus.p_q !== 16'h0000) $display("FAIL mid_async_p_q: got %h want 0000", bus.p_q);
        else n_pass++;
        n_total++;
        if (bus.ovf_q !== 1'b0) $display("FAIL mid_async_ovf_q: got %b want 0", bus.ovf_q);
        else n_pass++;
        n_total++;
        if (bus.p !== 16'h0100) $display("FAIL mid_p_hold: got %h want 0100", bus.p);
        else n_pass++;
        @(posedge HCLK);
        #1;
        n_total++;
        if (bus.p_q !== 16'h0000) $display("FAIL mid_held_p_q: got %h want 0000", bus.p_q);
        else n_pass++;
        @(negedge HCLK);
        HRESETn = 1'b1;
        bus.a = 16'h0100;
        bus.b = 16'h0100;
        @(negedge HCLK);
        n_total++;
        if (bus.p_q !== 16'h0000 || bus.ovf_q !== 1'b1)
            $display("FAIL mid_first_capture: got p_q=%h ovf_q=%b want p_q=0000 ovf_q=1",
                     bus.p_q, bus.ovf_q);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        bus.a   = '0;
        bus.b   = '0;
        HRESETn = 1'b0;
        test_reset();
        test_directed();
        test_random8();
        test_random16();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
